// File: rtl/frame_loader.sv
// frame_loader: assembles a serial word stream into small/big half-frames of a 4x4 frame
// and strobes each completed half into the register file.
module frame_loader #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] frame_0_out,
  output logic [DATA_W-1:0] frame_1_out,
  output logic [DATA_W-1:0] frame_2_out,
  output logic [DATA_W-1:0] frame_3_out,
  output logic [DATA_W-1:0] frame_4_out,
  output logic [DATA_W-1:0] frame_5_out,
  output logic [DATA_W-1:0] frame_6_out,
  output logic [DATA_W-1:0] frame_7_out,
  output logic [DATA_W-1:0] frame_8_out,
  output logic [DATA_W-1:0] frame_9_out,
  output logic [DATA_W-1:0] frame_10_out,
  output logic [DATA_W-1:0] frame_11_out,
  output logic [DATA_W-1:0] frame_12_out,
  output logic [DATA_W-1:0] frame_13_out,
  output logic [DATA_W-1:0] frame_14_out,
  output logic [DATA_W-1:0] frame_15_out,
  output logic              write,
  output logic              Small_or_Big,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_count
);
  // bit 0 marks a commit state, bit 1 marks the big (columns 2-3) half
  typedef enum logic [1:0] {FILL_SMALL = 2'd0, COMMIT_SMALL = 2'd1, FILL_BIG = 2'd2, COMMIT_BIG = 2'd3} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_cnt;
  logic              w_xfer;
  logic [3:0]        w_idx;
  logic [DATA_W-1:0] r_frame [16];
  logic              r_write, r_done;
  logic [CNT_W-1:0]  r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_SMALL;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= flush ? 3'd0 : r_cnt + {2'b0, w_xfer};
      r_write <= w_next[0];
      r_done  <= w_next == COMMIT_BIG;
      if (r_state == COMMIT_BIG && !flush) r_count <= r_count + CNT_W'(1);
    end
  end
  always_comb begin
    w_next = flush ? FILL_SMALL :
             r_state == COMMIT_SMALL ? FILL_BIG :
             r_state == COMMIT_BIG ? FILL_SMALL :
             (w_xfer && r_cnt == 3'd7) ? state_t'({r_state[1], 1'b1}) : r_state;
  end
  // index = 4*row + 2*big + col with row = cnt>>1, col = cnt&1
  always_comb begin
    in_ready = !r_state[0] && !flush;
    w_xfer   = in_valid && in_ready;
    w_idx    = {r_cnt[2:1], r_state[1], r_cnt[0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_frame[i] <= '0;
    end else if (w_xfer) begin
      r_frame[w_idx] <= in_data;
    end
  end
  assign frame_0_out  = r_frame[0];
  assign frame_1_out  = r_frame[1];
  assign frame_2_out  = r_frame[2];
  assign frame_3_out  = r_frame[3];
  assign frame_4_out  = r_frame[4];
  assign frame_5_out  = r_frame[5];
  assign frame_6_out  = r_frame[6];
  assign frame_7_out  = r_frame[7];
  assign frame_8_out  = r_frame[8];
  assign frame_9_out  = r_frame[9];
  assign frame_10_out = r_frame[10];
  assign frame_11_out = r_frame[11];
  assign frame_12_out = r_frame[12];
  assign frame_13_out = r_frame[13];
  assign frame_14_out = r_frame[14];
  assign frame_15_out = r_frame[15];
  assign write        = r_write;
  assign Small_or_Big = r_state[1];
  assign frame_done   = r_done;
  assign frame_count  = r_count;
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized stream against a slot-order model; commits checked from a scoreboard queue.
module tb_frame_loader;
  logic clk = 1'b0;
  logic rst, flush, in_valid;
  logic [31:0] in_data;
  logic in_ready, write, sob, done;
  logic [31:0] fo [16];
  logic [7:0] count;
  logic in_ready_b, write_b, sob_b, done_b;
  logic [31:0] fob [16];
  logic [1:0] count_b;
  always #5 clk = ~clk;

  frame_loader #(.DATA_W(32), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_0_out(fo[0]), .frame_1_out(fo[1]), .frame_2_out(fo[2]), .frame_3_out(fo[3]),
    .frame_4_out(fo[4]), .frame_5_out(fo[5]), .frame_6_out(fo[6]), .frame_7_out(fo[7]),
    .frame_8_out(fo[8]), .frame_9_out(fo[9]), .frame_10_out(fo[10]), .frame_11_out(fo[11]),
    .frame_12_out(fo[12]), .frame_13_out(fo[13]), .frame_14_out(fo[14]), .frame_15_out(fo[15]),
    .write(write), .Small_or_Big(sob), .frame_done(done), .frame_count(count));

  frame_loader #(.DATA_W(32), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .frame_0_out(fob[0]), .frame_1_out(fob[1]), .frame_2_out(fob[2]), .frame_3_out(fob[3]),
    .frame_4_out(fob[4]), .frame_5_out(fob[5]), .frame_6_out(fob[6]), .frame_7_out(fob[7]),
    .frame_8_out(fob[8]), .frame_9_out(fob[9]), .frame_10_out(fob[10]), .frame_11_out(fob[11]),
    .frame_12_out(fob[12]), .frame_13_out(fob[13]), .frame_14_out(fob[14]), .frame_15_out(fob[15]),
    .write(write_b), .Small_or_Big(sob_b), .frame_done(done_b), .frame_count(count_b));

  typedef struct packed { logic sob; logic [511:0] f; logic [31:0] cnt; } ev_t;
  ev_t q[$];
  int checks = 0, failures = 0;
  logic [511:0] m_f;
  int m_pos, m_count;
  logic m_commit;

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic logic [511:0] pk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = fo[i];
    return r;
  endfunction

  // stream position i -> frame index: first 8 fill columns 0-1 row by row, next 8 columns 2-3
  function automatic int slot(input int i);
    return (i < 8) ? 4 * (i / 2) + i % 2 : 4 * ((i - 8) / 2) + 2 + i % 2;
  endfunction

  task automatic model_reset();
    m_f = '0; m_pos = 0; m_count = 0; m_commit = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic fl, output logic acc);
    logic er;
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_data = d; flush = fl;
    #1;
    er = !m_commit && !fl;
    chk("in_ready", {511'b0, in_ready}, {511'b0, er});
    @(posedge clk);
    acc = v && er;
    if (fl) begin
      m_pos = 0; m_commit = 1'b0;
    end else if (m_commit) begin
      if (m_pos == 0) m_count++;
      m_commit = 1'b0;
    end else if (acc) begin
      m_f[slot(m_pos)*32 +: 32] = d;
      m_pos = (m_pos + 1) % 16;
      if (m_pos % 8 == 0) begin
        m_commit = 1'b1;
        q.push_back('{sob: (m_pos == 0), f: m_f, cnt: m_count});
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input bit gaps);
    logic acc, v;
    int n;
    acc = 1'b0; n = 0;
    while (!acc) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      step(v, v ? (m_commit ? 32'hDEADBEEF : w) : $urandom, 1'b0, acc);
      n++;
      if (n > 60) begin
        $display("FAIL send_timeout actual=%0d required<=60", n);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "stalled");
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, $urandom, 1'b0, acc);
  endtask

  task automatic check_cleared();
    chk("rst_write", {511'b0, write}, '0);
    chk("rst_done", {511'b0, done}, '0);
    chk("rst_sob", {511'b0, sob}, '0);
    chk("rst_count", {504'b0, count}, '0);
    chk("rst_count_b", {510'b0, count_b}, '0);
    chk("rst_frame", pk(), '0);
  endtask

  always @(negedge clk) begin
    if (write) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=1 required=0");
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("commit_sob", {511'b0, sob}, {511'b0, e.sob});
        chk("commit_done", {511'b0, done}, {511'b0, e.sob});
        chk("commit_frame", pk(), e.f);
        chk("commit_count", {504'b0, count}, {504'b0, e.cnt[7:0]});
        chk("commit_count_b", {510'b0, count_b}, {510'b0, e.cnt[1:0]});
        chk("commit_write_b", {511'b0, write_b}, 512'd1);
      end
    end else if (done) begin
      checks++; failures++;
      $display("FAIL done_without_write actual=1 required=0");
    end
  end

  initial begin
    logic acc;
    logic [511:0] first;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared();
    // back-to-back stream 0x100+i
    for (int i = 0; i < 16; i++) send(32'h100 + i, 1'b0);
    idle(2);
    chk("frame_2", {480'b0, fo[2]}, 512'h108);
    chk("frame_15", {480'b0, fo[15]}, 512'h10F);
    chk("frame_5", {480'b0, fo[5]}, 512'h103);
    chk("count_1", {504'b0, count}, 512'd1);
    first = pk();
    // same stream with random valid gaps; also overwrite frame with different data first
    for (int i = 0; i < 16; i++) send($urandom, 1'b1);
    idle(2);
    for (int i = 0; i < 16; i++) send(32'h100 + i, 1'b1);
    idle(2);
    chk("gapped_frame", pk(), first);
    chk("count_3", {504'b0, count}, 512'd3);
    // flush after 11 accepted words
    for (int i = 0; i < 11; i++) send($urandom, 1'b1);
    step(1'b1, 32'hBADC0DE5, 1'b1, acc);
    idle(3);
    chk("flush_count", {504'b0, count}, 512'd3);
    for (int i = 0; i < 16; i++) send($urandom, 1'b1);
    idle(2);
    // reset during the COMMIT_BIG cycle
    for (int i = 0; i < 16; i++) send($urandom, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom; flush = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_cleared();
    // five frames: narrow counter wraps 1,2,3,0,1
    for (int i = 0; i < 80; i++) send($urandom, 1'b1);
    idle(2);
    chk("count_5", {504'b0, count}, 512'd5);
    chk("count_b_wrap", {510'b0, count_b}, 512'd1);
    chk("queue_drained", 512'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the 4x4 frame register file (16 x 32-bit words, row-major index = 4*row + col).
- Accepts a serial 32-bit word stream over a valid/ready handshake and assembles it into two half-frames: "small" (columns 0-1) then "big" (columns 2-3).
- Presents all 16 words in parallel and issues a one-cycle write strobe with the half-select, which is the form the register file consumes.

Parameters:
- DATA_W, 32, word width.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk, in, 1, system clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, synchronous restart of frame assembly.
- in_valid, in, 1, upstream word valid.
- in_data, in, DATA_W, upstream word.
- in_ready, out, 1, loader can accept a word this cycle.
- frame_k_out (k = 0..15), out, DATA_W each, assembled frame word k, registered.
- write, out, 1, one-cycle commit strobe to the register file.
- Small_or_Big, out, 1, 0 = columns 0-1 half, 1 = columns 2-3 half.
- frame_done, out, 1, one-cycle pulse when a full frame commits.
- frame_count, out, CNT_W, number of completed frames.

Behaviour:
- States: FILL_SMALL, COMMIT_SMALL, FILL_BIG, COMMIT_BIG. A 3-bit word counter cnt runs 0..7.
- Reset (rst=1 at posedge) overrides everything:
  - state = FILL_SMALL, cnt = 0.
  - All frame_k_out = 0, write = 0, frame_done = 0, frame_count = 0.
  - Small_or_Big = 0.
- in_ready = (state is FILL_SMALL or FILL_BIG) and !flush. It is combinational from state and flush.
- Transfer occurs when in_valid && in_ready at a posedge.
- Slot mapping for a transfer with row = cnt>>1, col = cnt&1:
  - FILL_SMALL: index = 4*row + col. Order: 0,1,4,5,8,9,12,13.
  - FILL_BIG: index = 4*row + 2 + col. Order: 2,3,6,7,10,11,14,15.
  - On transfer, frame_<index>_out <= in_data and cnt increments.
  - All other frame words hold their value.
- The 8th transfer (cnt=7) wraps cnt to 0 and moves FILL_x to COMMIT_x.
- COMMIT_x lasts exactly one cycle:
  - write = 1 and in_ready = 0.
  - Next state is FILL_BIG from COMMIT_SMALL, or FILL_SMALL from COMMIT_BIG.
- write is registered and is 1 only while in a COMMIT state.
- frame_k_out values are stable throughout the write cycle, because no transfer can occur in COMMIT.
- Small_or_Big = 0 in FILL_SMALL/COMMIT_SMALL and 1 in FILL_BIG/COMMIT_BIG. It is constant for the whole write cycle.
- In COMMIT_BIG:
  - frame_done = 1 in the same cycle as write.
  - frame_count increments at the end of that cycle and wraps modulo 2^CNT_W.
- Latency and throughput:
  - 8th word accepted at edge N gives write=1 during cycle N..N+1, and in_ready returns at edge N+1.
  - With in_valid held high, a full frame takes 18 cycles (16 transfers + 2 commits).
- in_valid gaps stall the counter without penalty. in_data is ignored when no transfer occurs.
- flush (priority below rst, above all else):
  - state = FILL_SMALL, cnt = 0, write forced 0 that cycle.
  - A pending COMMIT is cancelled and frame_count is not incremented.
  - frame_k_out registers are NOT cleared.
  - The word presented in the flush cycle is not accepted.
- Reset mid-operation behaves exactly like reset from idle. No partial commit is emitted.

Test Plan:
- Reset, then 16 back-to-back words 0x100+i (i = 0..15), in_valid held high:
  - The i-th word lands at index order 0,1,4,5,8,9,12,13,2,3,6,7,10,11,14,15, e.g. frame_2_out = 0x108, frame_15_out = 0x10F.
  - write pulses twice, with Small_or_Big = 0 then 1.
  - frame_done is high once, coincident with the second write.
  - frame_count = 1.
  - in_ready is low exactly in the two commit cycles.
- Random in_valid gaps over the same stream: final frame contents identical to the first scenario, each write exactly one cycle, no word dropped or duplicated.
- in_valid held high during a commit cycle with in_data = 0xDEADBEEF: word not accepted; the next accepted word is the following stream word, with cnt unchanged by the commit cycle.
- flush asserted after 11 accepted words:
  - No further write occurs until 8 new words are sent.
  - The next commit has Small_or_Big = 0.
  - frame_8_out..frame_13_out retain their pre-flush values until overwritten.
  - frame_count is unchanged.
- rst asserted in the COMMIT_BIG cycle: write = 0 the next cycle, all frame_k_out = 0, frame_count = 0, state = FILL_SMALL.
- Three consecutive frames with CNT_W = 2 (reduced for this test): frame_count goes 1, 2, 3, and a fifth frame wraps it to 1.
